// File: rtl/mips_avalon_pkg.sv
// Shared types and constants for the Avalon-MM slave word memory.
package mips_avalon_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_t;

  // Seed and Fibonacci tap mask (taps 16,14,13,11) for the wait-jitter LFSR.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Request as seen on the bus; the copy latched at acceptance is authoritative.
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        rd;
    logic        wr;
  } req_t;

endpackage

// File: rtl/mips_avalon_lfsr16.sv
// 16-bit Fibonacci LFSR, advances one step per accepted transaction.
// Only instantiated when MIPS_MEM_RANDOM_WAIT_EN is defined.
module mips_avalon_lfsr16
  import mips_avalon_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        step,
  output logic [15:0] value
);

  logic fb;

  assign fb = ^(value & LFSR_TAPS);

  // Seed on reset, shift the parity of the tapped bits in at the bottom.
  always_ff @(posedge clk) begin
    if (rst)       value <= LFSR_SEED;
    else if (step) value <= {value[14:0], fb};
  end

endmodule

// File: rtl/mips_avalon_slave_mem.sv
// Avalon-MM slave word memory with programmable waitrequest stalls and
// sticky master-protocol violation detection.
// Optional build macro: MIPS_MEM_RANDOM_WAIT_EN adds 0..3 LFSR-driven
// extra wait cycles per transaction on top of WAIT_CYCLES.
module mips_avalon_slave_mem
  import mips_avalon_pkg::*;
#(
  parameter int ADDR_BITS   = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] address,
  input  logic        read,
  input  logic        write,
  input  logic [3:0]  byteenable,
  input  logic [31:0] writedata,
  output logic        waitrequest,
  output logic [31:0] readdata,
  output logic        protocol_err,
  output logic [1:0]  state_out
);

  localparam int DEPTH = 1 << ADDR_BITS;
  // Wide enough for WAIT_CYCLES plus the largest jitter (3).
  localparam int CNT_W = $clog2(WAIT_CYCLES + 4);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CNT_W-1:0]     wait_cnt;
  req_t                 req_q, req_in;
  logic                 accept, sample, wr_commit, err_set;
  logic [ADDR_BITS-1:0] cur_idx, req_idx, samp_idx;

  logic [31:0] mem [0:DEPTH-1];

  assign req_in    = '{addr: address, wdata: writedata, be: byteenable,
                       rd: read, wr: write};
  assign cur_idx   = address[ADDR_BITS+1:2];
  assign req_idx   = req_q.addr[ADDR_BITS+1:2];
  // IDLE->ACK (zero wait) samples the request still on the bus; otherwise
  // the latched index is used.
  assign samp_idx  = (state_q == IDLE) ? cur_idx : req_idx;
  assign state_out = state_q;

`ifdef MIPS_MEM_RANDOM_WAIT_EN
  logic [15:0] lfsr_val;
  logic        unused_lfsr;

  mips_avalon_lfsr16 u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .step  (accept),
    .value (lfsr_val)
  );

  assign wait_cnt    = CNT_W'(WAIT_CYCLES) + CNT_W'(lfsr_val[1:0]);
  assign unused_lfsr = ^lfsr_val[15:2];
`else
  assign wait_cnt = CNT_W'(WAIT_CYCLES);
`endif

  // Next-state, stall and event decode; reset overrides waitrequest high.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    accept      = 1'b0;
    sample      = 1'b0;
    wr_commit   = 1'b0;
    err_set     = 1'b0;
    waitrequest = 1'b1;
    case (state_q)
      IDLE: begin
        waitrequest = read | write;
        if (read | write) begin
          accept = 1'b1;
          cnt_d  = wait_cnt;
          // Both strobes high is resolved as a write but still flagged.
          if (address[1:0] != 2'b00 || (read && write)) err_set = 1'b1;
          if (wait_cnt != '0) begin
            state_d = WAIT;
          end else begin
            state_d = ACK;
            sample  = ~write;
          end
        end
      end
      WAIT: begin
        if (!read && !write) begin
          // Master abandoned the request: abort without touching memory.
          state_d = IDLE;
          cnt_d   = '0;
          err_set = 1'b1;
        end else begin
          if (req_in != req_q) err_set = 1'b1;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q <= CNT_W'(1)) begin
            state_d = ACK;
            sample  = ~req_q.wr;
          end
        end
      end
      ACK: begin
        waitrequest = 1'b0;
        wr_commit   = req_q.wr;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (rst) waitrequest = 1'b1;
  end

  // Control state, request latch, read data register and sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      req_q        <= '0;
      readdata     <= '0;
      protocol_err <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept)  req_q        <= req_in;
      if (sample)  readdata     <= mem[samp_idx];
      if (err_set) protocol_err <= 1'b1;
    end
  end

  // Byte-enabled write at the ACK edge; a reset in flight drops the write.
  // Contents are deliberately not cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst && wr_commit) begin
      for (int b = 0; b < 4; b++)
        if (req_q.be[b]) mem[req_idx][8*b +: 8] <= req_q.wdata[8*b +: 8];
    end
  end

endmodule

// File: tb/tb_mips_avalon_slave_mem.sv
// Self-checking bench for mips_avalon_slave_mem: directed protocol cases plus
// randomized read/write traffic against a word-array reference memory.
module tb_mips_avalon_slave_mem;

  localparam int W = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] address = '0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [3:0]  byteenable = '0;
  logic [31:0] writedata = '0;
  logic        waitrequest;
  logic [31:0] readdata;
  logic        protocol_err;
  logic [1:0]  state_out;

  int total = 0;
  int bad   = 0;

  logic [31:0] ref_mem [0:1023];
  bit          ref_ok  [0:1023];
  int          last_lat;

  mips_avalon_slave_mem #(.ADDR_BITS(10), .WAIT_CYCLES(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .address      (address),
    .read         (read),
    .write        (write),
    .byteenable   (byteenable),
    .writedata    (writedata),
    .waitrequest  (waitrequest),
    .readdata     (readdata),
    .protocol_err (protocol_err),
    .state_out    (state_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic check_lat(input string tag, input int lat);
`ifdef MIPS_MEM_RANDOM_WAIT_EN
    chk({tag, "_lat"}, {31'd0, (lat >= W + 1 && lat <= W + 4)}, 32'd1);
`else
    chk({tag, "_lat"}, 32'(lat), 32'(W + 1));
`endif
  endtask

  task automatic issue(input bit wr, input bit rd, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] be);
    @(negedge clk);
    address = a; writedata = d; byteenable = be; write = wr; read = rd;
  endtask

  task automatic idle();
    @(negedge clk);
    read = 1'b0; write = 1'b0;
  endtask

  // Counts stalled cycles from the current one until waitrequest drops.
  task automatic finish_x(output int lat, output logic [31:0] rd);
    lat = 0;
    #1;
    while (waitrequest !== 1'b0 && lat < 20) begin
      @(negedge clk); #1;
      lat++;
    end
    if (lat >= 20) chk("timeout", {31'd0, waitrequest}, 32'd0);
    rd = readdata;
  endtask

  function automatic void ref_wr(input int idx, input logic [31:0] d, input logic [3:0] be);
    for (int b = 0; b < 4; b++)
      if (be[b]) ref_mem[idx][8*b +: 8] = d[8*b +: 8];
    ref_ok[idx] = 1'b1;
  endfunction

  // One transaction, request left asserted on return (caller decides idle).
  task automatic xact(input bit wr, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] be, input string tag);
    int          lat;
    logic [31:0] rdat;
    int          idx;
    issue(wr, !wr, a, d, be);
    finish_x(lat, rdat);
    last_lat = lat;
    check_lat(tag, lat);
    idx = int'(a[11:2]);
    if (wr) ref_wr(idx, d, be);
    else if (ref_ok[idx]) chk(tag, rdat, ref_mem[idx]);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; read = 1'b0; write = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int          lat;
    logic [31:0] rdat;
    int          pool [8];
    int          lats [16];
    logic [31:0] a;

    // Reset state: no request, yet waitrequest held high while in reset.
    repeat (3) @(negedge clk);
    #1;
    chk("rst_wreq", {31'd0, waitrequest}, 32'd1);
    chk("rst_state", {30'd0, state_out}, 32'd0);
    chk("rst_rdata", readdata, 32'd0);
    chk("rst_err", {31'd0, protocol_err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("idle_wreq", {31'd0, waitrequest}, 32'd0);

    // Basic write then read back.
    xact(1, 32'h1000, 32'hDEADBEEF, 4'hF, "wr1000"); idle();
    xact(0, 32'h1000, 32'h0, 4'h0, "rd1000");       idle();
    chk("rd1000_val", ref_mem[0], 32'hDEADBEEF);

    // Byte-enabled merge and zero byteenable.
    xact(1, 32'h0100, 32'h11223344, 4'hF, "pre100");   idle();
    xact(1, 32'h0100, 32'hAABBCCDD, 4'b0101, "be5");   idle();
    xact(0, 32'h0100, 32'h0, 4'h0, "rd_be5");          idle();
    chk("be5_val", readdata, 32'h11BB33DD);
    xact(1, 32'h0100, 32'hFFFFFFFF, 4'h0, "be0");      idle();
    xact(0, 32'h0100, 32'h0, 4'h0, "rd_be0");          idle();
    chk("be0_val", readdata, 32'h11BB33DD);

    // Four back-to-back writes with write held high throughout.
    for (int i = 0; i < 4; i++)
      xact(1, 32'h200 + 32'(4 * i), 32'hB0B0_0000 + 32'(i), 4'hF, "b2b");
    idle();
    for (int i = 0; i < 4; i++) begin
      xact(0, 32'h200 + 32'(4 * i), 32'h0, 4'h0, "b2b_rd"); idle();
    end
    chk("b2b_err", {31'd0, protocol_err}, 32'd0);

    // Address changed during WAIT: latched address wins, error flagged.
    xact(1, 32'h20, 32'h0000_0020, 4'hF, "pre20"); idle();
    xact(1, 32'h24, 32'h0000_0024, 4'hF, "pre24"); idle();
    issue(1, 0, 32'h20, 32'hCAFE0001, 4'hF);
    @(negedge clk);
    address = 32'h24;
    finish_x(lat, rdat);
    ref_wr(8, 32'hCAFE0001, 4'hF);
    idle();
    chk("achg_err", {31'd0, protocol_err}, 32'd1);
    xact(0, 32'h20, 32'h0, 4'h0, "achg_rd20"); idle();
    xact(0, 32'h24, 32'h0, 4'h0, "achg_rd24"); idle();

    // Write dropped mid-WAIT: aborts to IDLE, memory untouched.
    do_reset();
    xact(1, 32'h30, 32'h3030_3030, 4'hF, "pre30"); idle();
    issue(1, 0, 32'h30, 32'h0BAD_0BAD, 4'hF);
    @(negedge clk);
    write = 1'b0;
    @(negedge clk); #1;
    chk("drop_state", {30'd0, state_out}, 32'd0);
    chk("drop_err", {31'd0, protocol_err}, 32'd1);
    xact(0, 32'h30, 32'h0, 4'h0, "drop_rd"); idle();

    // Read and write both high: resolved as a write, error flagged.
    do_reset();
    issue(1, 1, 32'h50, 32'h5151_5151, 4'hF);
    finish_x(lat, rdat);
    ref_wr(20, 32'h5151_5151, 4'hF);
    idle();
    chk("both_err", {31'd0, protocol_err}, 32'd1);
    xact(0, 32'h50, 32'h0, 4'h0, "both_rd"); idle();

    // Reset during WAIT of a misaligned write: write discarded, state cleared.
    do_reset();
    xact(1, 32'h40, 32'h4444_4444, 4'hF, "pre40"); idle();
    xact(0, 32'h40, 32'h0, 4'h0, "rd40");          idle();
    issue(1, 0, 32'h41, 32'h9999_9999, 4'hF);
    @(negedge clk); #1;
    chk("mis_err", {31'd0, protocol_err}, 32'd1);
    rst = 1'b1; read = 1'b0; write = 1'b0;
    #1;
    chk("rstw_wreq0", {31'd0, waitrequest}, 32'd1);
    @(negedge clk); #1;
    chk("rstw_wreq1", {31'd0, waitrequest}, 32'd1);
    chk("rstw_state", {30'd0, state_out}, 32'd0);
    rst = 1'b0;
    #1;
    chk("rstw_rdata", readdata, 32'd0);
    chk("rstw_err", {31'd0, protocol_err}, 32'd0);
    xact(0, 32'h40, 32'h0, 4'h0, "rstw_rd40"); idle();

    // Randomized traffic over a small pool with aliasing upper bits.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      pool[i] = 512 + 16 * i + int'($urandom_range(0, 15));
      a = {$urandom() >> 12, 10'(pool[i]), 2'b00};
      xact(1, a, $urandom(), 4'hF, "rinit"); idle();
    end
    for (int i = 0; i < 60; i++) begin
      a = {$urandom() >> 12, 10'(pool[$urandom_range(0, 7)]), 2'b00};
      if ($urandom_range(0, 1) == 1)
        xact(1, a, $urandom(), 4'($urandom_range(0, 15)), "rwr");
      else
        xact(0, a, 32'h0, 4'h0, "rrd");
      if ($urandom_range(0, 1) == 1) idle();
    end
    idle();
    chk("rand_err", {31'd0, protocol_err}, 32'd0);

    // Latency sequence must repeat identically from reset.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      xact(0, {22'd0, 10'(pool[i % 8])} << 2, 32'h0, 4'h0, "seq1"); idle();
      lats[i] = last_lat;
    end
    do_reset();
    for (int i = 0; i < 16; i++) begin
      xact(0, {22'd0, 10'(pool[i % 8])} << 2, 32'h0, 4'h0, "seq2"); idle();
      chk("seq_repeat", 32'(last_lat), 32'(lats[i]));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mips_avalon_slave_mem.md
Name: mips_avalon_slave_mem

Overview:
Avalon-MM slave word memory that answers the CPU data-side write buffer and cache read-miss requests. It is the responder end of the same bus: it accepts read and write requests, stalls them with waitrequest for a configurable number of cycles, then completes them with byte-enabled writes or registered read data. It is used as the main-memory model in CPU testbenches and as a small on-chip RAM in synthesis, and it flags master-side protocol violations.

Parameters:
ADDR_BITS, 10, log2 of memory depth in 32-bit words (1024 words = 4 KiB).
WAIT_CYCLES, 2, number of extra wait cycles inserted per transaction (0 allowed).

Ports:
clk  in  1  clock; all state changes on the rising edge.
rst  in  1  reset, synchronous, active-high.
address  in  32  byte address from the master.
read  in  1  read request.
write  in  1  write request.
byteenable  in  4  byte lanes for writes; bit i selects writedata[8i+7:8i].
writedata  in  32  write data.
waitrequest  out  1  stall; transaction completes in the cycle where the request is high and waitrequest is low.
readdata  out  32  read data; valid in the completion cycle of a read.
protocol_err  out  1  sticky master-violation flag.
state_out  out  2  debug state.

Behaviour:
- Word index = address[ADDR_BITS+1:2]. Upper address bits are ignored, so addresses alias modulo the memory size. address[1:0]!=0 sets protocol_err; the access still proceeds using the word index.
- States: IDLE=0, WAIT=1, ACK=2.
- IDLE:
  - waitrequest = read|write (combinational).
  - On an edge with read|write high: latch address, writedata, byteenable and op (write if write, else read).
  - Load the counter with WAIT_CYCLES; go to WAIT if WAIT_CYCLES>0, else ACK.
- WAIT:
  - waitrequest=1; the counter decrements each cycle.
  - When the counter reaches 1, go to ACK.
  - On the transition into ACK, a latched read samples mem[index] into readdata.
- ACK:
  - waitrequest=0 combinationally.
  - A latched write updates only the enabled bytes at this edge. byteenable=0 completes with no change.
  - Always return to IDLE next cycle. A master still asserting a request is treated as a new transaction, so back-to-back requests see a one-cycle waitrequest in IDLE.
- Latency: request first seen in cycle N; completion cycle = N+1+WAIT_CYCLES. Total transaction length is WAIT_CYCLES+2 cycles.
- readdata holds its last value outside read completions and resets to 0.
- The latched request is authoritative. Any change of address, writedata, byteenable, read or write while in WAIT sets protocol_err.
- Request dropped in WAIT (read=write=0): abort to IDLE, no memory write, protocol_err set.
- read and write both high in IDLE: treated as a write; protocol_err set.
- Reset while rst=1, including mid-transaction:
  - state=IDLE, counter=0, readdata=0, protocol_err=0, waitrequest forced to 1.
  - A pending write is discarded.
  - Memory contents are not cleared.
- protocol_err is cleared only by rst.

Optional Feature:
MIPS_MEM_RANDOM_WAIT_EN:
- Defined:
  - A 16-bit Fibonacci LFSR with taps 16,14,13,11 is seeded with 16'hACE1 on rst.
  - It advances once per accepted transaction.
  - The per-transaction wait count = WAIT_CYCLES + lfsr[1:0] (0..3 extra cycles).
- Undefined: the wait count is exactly WAIT_CYCLES and no LFSR logic exists.

Decomposition:
- Package mips_avalon_pkg: state_t enum (IDLE/WAIT/ACK), LFSR_SEED=16'hACE1, LFSR tap mask 16'hB400.
- Sub-module mips_avalon_lfsr16 (clk, rst, step, value[15:0]), instantiated only under MIPS_MEM_RANDOM_WAIT_EN.

Test Plan:
- Write 0x1000 data 0xDEADBEEF be=4'hF, WAIT_CYCLES=2 -> waitrequest high 3 cycles, low in cycle 4; a later read of 0x1000 returns 0xDEADBEEF in its completion cycle.
- Preload 0x11223344; write 0xAABBCCDD be=4'b0101 -> read returns 0x11BB33DD. Write with be=0 -> word unchanged.
- Write buffer issuing 4 back-to-back writes with write held high -> each takes 4 cycles with a one-cycle waitrequest in IDLE; all 4 words correct; protocol_err stays 0.
- Address changed 0x20->0x24 during WAIT -> protocol_err=1; the write lands at 0x20. Read dropped mid-WAIT -> state returns to IDLE, no write, protocol_err=1.
- rst asserted in WAIT of a write to 0x40 -> waitrequest=1 during reset; mem[0x40] unchanged; readdata=0, protocol_err=0 after reset.
- With MIPS_MEM_RANDOM_WAIT_EN, WAIT_CYCLES=0: 16 reads -> every completion latency is within 1..4 cycles; the latency sequence is identical across two runs from reset.
